tko_stream_loader: RTL

- Hardware replacement for the simulation-only image preload: accepts a .tko program image as a byte stream and writes it into the CPU's byte-addressed memory.
- Sits directly upstream of cpu; drives the memory write port and holds the CPU in reset until the image is fully written.
- Releases the CPU only after a complete, in-range image has been written.

---
 rtl/tko_loader_pkg.sv | 13 +
 rtl/loader_checksum.sv | 24 ++
 rtl/tko_stream_loader.sv | 105 ++++++++++
 3 files changed

// File: rtl/tko_loader_pkg.sv
// tko_loader_pkg: shared state encoding and default memory geometry for the .tko stream loader
package tko_loader_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} loader_state_t;

  localparam int ADDR_W_DEF    = 19;
  localparam int LOAD_BASE_DEF = 'h2000;

  function automatic int capacity(input int addr_w, input int base);
    return (1 << addr_w) - base;
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// loader_checksum: 8-bit wrapping sum of written image bytes, compared against the trailing checksum byte
module loader_checksum (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  input  logic [7:0] chk_i,
  output logic       match_o
);

  logic [7:0] sum_q, sum_d;

  // clear wins over add so an aborted image never leaks into the next one
  always_comb sum_d = clr_i ? 8'h00 : add_i ? sum_q + data_i : sum_q;

  // running sum register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sum_q <= 8'h00;
    else         sum_q <= sum_d;

  assign match_o = sum_q == chk_i;

endmodule

// File: rtl/tko_stream_loader.sv
// tko_stream_loader: writes a .tko byte stream into CPU memory from LOAD_BASE and holds the CPU in reset until done; LOADER_CHECKSUM_EN makes the last byte a checksum
module tko_stream_loader
  import tko_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LOAD_BASE = LOAD_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'(capacity(ADDR_W, LOAD_BASE));
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(LOAD_BASE);

  loader_state_t     state_q, state_d;
  logic              armed_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              accept, abort, at_cap, wr, csum_byte, csum_ok;

  // armed_q keeps s_ready low while reset is asserted and for the first cycle after it
  assign s_ready = armed_q && (state_q == IDLE || (state_q == LOAD && !restart));
  assign accept  = s_valid && s_ready;
  assign abort   = restart && state_q != IDLE;
  assign at_cap  = count_q == CAP;
  assign wr      = accept && !csum_byte && !at_cap;

`ifdef LOADER_CHECKSUM_EN
  assign csum_byte = s_last;
  loader_checksum u_csum (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (abort),
    .add_i  (wr),
    .data_i (s_data),
    .chk_i  (s_data),
    .match_o(csum_ok)
  );
`else
  assign csum_byte = 1'b0;
  assign csum_ok   = 1'b0;
`endif

  // next state: restart outranks everything, an accepted byte decides done/error/continue
  always_comb begin
    state_d = state_q;
    if (abort)
      state_d = IDLE;
    else if (accept)
      state_d = csum_byte ? (csum_ok ? DONE : ERR) : at_cap ? ERR : s_last ? DONE : LOAD;
  end

  // registered write port and counter; cpu_reset drops only once DONE has been held a cycle
  always_comb begin
    we_d      = wr;
    addr_d    = wr ? BASE + count_q[ADDR_W-1:0] : addr_q;
    wdata_d   = wr ? s_data : wdata_q;
    count_d   = abort ? '0 : wr ? count_q + 1'b1 : count_q;
    cpu_rst_d = !(state_q == DONE && !restart);
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      count_q   <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      count_q   <= count_d;
      cpu_rst_q <= cpu_rst_d;
    end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_reset  = cpu_rst_q;
  assign load_done  = state_q == DONE;
  assign load_err   = state_q == ERR;
  assign byte_count = count_q;

endmodule
